// File: rtl/refresh_frame_scheduler.sv
// refresh_frame_scheduler: Avalon-MM slave that runs tick division, tear-free buffer swaps and frame counting off the refresh edge.
// Ports: clk/reset_n clock and async active-low reset; address/chipselect/write_n/writedata/readdata Avalon-MM slave
// (readdata registered, 1-cycle latency); irq level interrupt; refresh_in async vsync level; front_buf_sel scanned-out
// buffer; frame_tick one-cycle pulse per divided tick.
module refresh_frame_scheduler #(
  parameter int DIV_WIDTH  = 8,
  parameter int FCNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        refresh_in,
  output logic        front_buf_sel,
  output logic        frame_tick
);
  typedef enum logic {IDLE, PENDING} state_t;
  state_t r_state, w_state_nxt;
  logic r_s1, r_s2, r_s3;
  logic r_enable, r_tick_ie, r_swap_ie;
  logic [DIV_WIDTH-1:0] r_divider, r_presc;
  logic [FCNT_WIDTH-1:0] r_fcnt;
  logic r_tick_evt, r_swap_evt, r_front, r_frame_tick;
  logic [31:0] r_readdata, w_rd_mux;
  logic w_edge, w_wr, w_tick, w_commit, w_pending;
  assign w_edge  = r_s2 & ~r_s3;
  assign w_wr    = chipselect & ~write_n;
  assign w_tick  = r_enable & w_edge & (r_presc == r_divider);
  assign w_pending = (r_state == PENDING);
  assign irq = (r_tick_evt & r_tick_ie) | (r_swap_evt & r_swap_ie);
  assign readdata = r_readdata;
  assign front_buf_sel = r_front;
  assign frame_tick = r_frame_tick;
  // A swap write arriving while PENDING is ignored, so a request can never double-toggle.
  always_comb begin
    w_state_nxt = r_state;
    w_commit = 1'b0;
    if (r_state == IDLE) begin
      if (w_wr && address == 3'd3) w_state_nxt = PENDING;
    end else if (w_edge && r_enable) begin
      w_state_nxt = IDLE;
      w_commit = 1'b1;
    end
  end
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      3'd0: w_rd_mux = {29'd0, r_front, w_pending, r_s2};
      3'd1: w_rd_mux = {29'd0, r_swap_ie, r_tick_ie, r_enable};
      3'd2: w_rd_mux = 32'(r_divider);
      3'd3: w_rd_mux = {31'd0, w_pending};
      3'd4: w_rd_mux = {30'd0, r_swap_evt, r_tick_evt};
      3'd5: w_rd_mux = 32'(r_fcnt);
      default: w_rd_mux = 32'd0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      {r_s1, r_s2, r_s3} <= 3'b000;
      {r_enable, r_tick_ie, r_swap_ie} <= 3'b000;
      r_divider <= '0;
      r_presc <= '0;
      r_fcnt <= '0;
      r_tick_evt <= 1'b0;
      r_swap_evt <= 1'b0;
      r_front <= 1'b0;
      r_frame_tick <= 1'b0;
      r_readdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      {r_s1, r_s2, r_s3} <= {refresh_in, r_s1, r_s2};
      r_readdata <= w_rd_mux;
      r_frame_tick <= w_tick;
      if (w_commit) r_front <= ~r_front;
      if (w_wr && address == 3'd1) {r_swap_ie, r_tick_ie, r_enable} <= writedata[2:0];
      if (w_wr && address == 3'd2) r_divider <= writedata[DIV_WIDTH-1:0];
      // A divider write restarts the prescaler even if an edge lands in the same cycle.
      if (w_wr && address == 3'd2) r_presc <= '0;
      else if (r_enable && w_edge) r_presc <= w_tick ? '0 : r_presc + 1'b1;
      // Clear write beats a coincident edge so software sees a clean zero.
      if (w_wr && address == 3'd5) r_fcnt <= '0;
      else if (w_edge) r_fcnt <= r_fcnt + 1'b1;
      // New events win over a coincident W1C so none is lost.
      r_tick_evt <= w_tick   | (r_tick_evt & ~(w_wr && address == 3'd4 && writedata[0]));
      r_swap_evt <= w_commit | (r_swap_evt & ~(w_wr && address == 3'd4 && writedata[1]));
    end
  end
endmodule

// File: tb/tb_refresh_frame_scheduler.sv
// tb_refresh_frame_scheduler: directed self-checking bench for refresh_frame_scheduler.
module tb_refresh_frame_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0;
  logic write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic irq;
  logic refresh_in = 1'b0;
  logic front_buf_sel;
  logic frame_tick;
  int n_cmp = 0;
  int n_bad = 0;
  refresh_frame_scheduler #(.DIV_WIDTH(8), .FCNT_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .irq(irq),
    .refresh_in(refresh_in), .front_buf_sel(front_buf_sel), .frame_tick(frame_tick)
  );
  always #5 clk = ~clk;
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask
  // One refresh pulse; optionally a write placed in the exact cycle the edge is seen.
  task automatic pulse(input logic do_wr, input logic [2:0] a, input logic [31:0] d, output logic seen);
    seen = 1'b0;
    @(negedge clk);
    refresh_in = 1'b1;
    repeat (2) begin @(negedge clk); seen |= frame_tick; end
    if (do_wr) begin address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0; end
    @(negedge clk);
    seen |= frame_tick;
    chipselect = 1'b0; write_n = 1'b1;
    repeat (2) begin @(negedge clk); seen |= frame_tick; end
    refresh_in = 1'b0;
    repeat (4) begin @(negedge clk); seen |= frame_tick; end
  endtask
  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    n_cmp++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_readdata got %h exp 0", readdata); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b exp 0", irq); end
    n_cmp++; if (front_buf_sel !== 1'b0) begin n_bad++; $display("FAIL reset_front got %b exp 0", front_buf_sel); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
    wr(3'd6, 32'hFFFF_FFFF);
    wr(3'd7, 32'hFFFF_FFFF);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), d);
      n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d got %h exp 0", i, d); end
    end
  endtask
  task automatic test_tick();
    logic [31:0] d;
    logic seen;
    wr(3'd2, 32'd2);
    wr(3'd1, 32'h1);
    rd(3'd2, d);
    n_cmp++; if (d !== 32'd2) begin n_bad++; $display("FAIL divider_rb got %h exp 2", d); end
    for (int i = 1; i <= 7; i++) begin
      pulse(1'b0, 3'd0, 32'd0, seen);
      n_cmp++; if (seen !== (i == 3 || i == 6)) begin n_bad++; $display("FAIL tick_edge%0d got %b exp %b", i, seen, (i == 3 || i == 6)); end
    end
    rd(3'd5, d);
    n_cmp++; if (d !== 32'd7) begin n_bad++; $display("FAIL fcnt7 got %0d exp 7", d); end
    rd(3'd4, d);
    n_cmp++; if (d !== 32'd1) begin n_bad++; $display("FAIL event_tick got %h exp 1", d); end
  endtask
  task automatic test_swap();
    logic [31:0] d;
    logic seen;
    wr(3'd4, 32'h3);
    wr(3'd1, 32'h5);
    wr(3'd3, 32'h0);
    wr(3'd3, 32'h1);
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL swap_status_pend got %h exp 2", d); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL swap_irq_pre got %b exp 0", irq); end
    pulse(1'b0, 3'd0, 32'd0, seen);
    n_cmp++; if (front_buf_sel !== 1'b1) begin n_bad++; $display("FAIL swap_front got %b exp 1", front_buf_sel); end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL swap_status_done got %h exp 4", d); end
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL swap_irq got %b exp 1", irq); end
    wr(3'd4, 32'h2);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL swap_irq_clr got %b exp 0", irq); end
    rd(3'd4, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL swap_event_clr got %h exp 0", d); end
  endtask
  task automatic test_swap_on_edge();
    logic [31:0] d;
    logic seen;
    pulse(1'b1, 3'd3, 32'd0, seen);
    n_cmp++; if (front_buf_sel !== 1'b1) begin n_bad++; $display("FAIL edge_swap_notoggle got %b exp 1", front_buf_sel); end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h6) begin n_bad++; $display("FAIL edge_swap_status got %h exp 6", d); end
    pulse(1'b0, 3'd0, 32'd0, seen);
    n_cmp++; if (front_buf_sel !== 1'b0) begin n_bad++; $display("FAIL edge_swap_toggle got %b exp 0", front_buf_sel); end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL edge_swap_status2 got %h exp 0", d); end
  endtask
  task automatic test_coincident();
    logic [31:0] d;
    logic seen;
    wr(3'd2, 32'd0);
    pulse(1'b1, 3'd4, 32'h1, seen);
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL div0_tick got %b exp 1", seen); end
    rd(3'd4, d);
    n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL w1c_vs_set got %h exp 3", d); end
    wr(3'd4, 32'h1);
    rd(3'd4, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL w1c_b0_only got %h exp 2", d); end
    pulse(1'b1, 3'd5, 32'd0, seen);
    rd(3'd5, d);
    n_cmp++; if (d !== 32'd0) begin n_bad++; $display("FAIL fcnt_clr_edge got %0d exp 0", d); end
  endtask
  task automatic test_disabled_pending_reset();
    logic [31:0] d;
    logic seen;
    wr(3'd1, 32'h0);
    wr(3'd3, 32'h0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 3'd0, 32'd0, seen);
    n_cmp++; if (front_buf_sel !== 1'b0) begin n_bad++; $display("FAIL dis_front got %b exp 0", front_buf_sel); end
    rd(3'd5, d);
    n_cmp++; if (d !== 32'd3) begin n_bad++; $display("FAIL dis_fcnt got %0d exp 3", d); end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL dis_pending got %h exp 2", d); end
    wr(3'd1, 32'h7);
    do_reset();
    n_cmp++; if (irq !== 1'b0 || front_buf_sel !== 1'b0 || frame_tick !== 1'b0 || readdata !== 32'd0) begin
      n_bad++; $display("FAIL midreset_outs got irq=%b fb=%b ft=%b rd=%h exp all 0", irq, front_buf_sel, frame_tick, readdata);
    end
    rd(3'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_status got %h exp 0", d); end
    rd(3'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_ctrl got %h exp 0", d); end
    rd(3'd5, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL midreset_fcnt got %h exp 0", d); end
  endtask
  initial begin
    test_reset();
    test_tick();
    test_swap();
    test_swap_on_edge();
    test_coincident();
    test_disabled_pending_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
